// File: rtl/comp_pkg.sv
// ---------------------------------------------------------------------------
// comp_pkg
//   Shared definitions for the digit-serial comparator family.
//   - CMP_* : compare-mode encodings carried on the 'mode' bus signal
//   - state_t : sequencing states of the serial comparator
//   - modeResult() : folds the raw (gt, eq) flags into the selected result
// ---------------------------------------------------------------------------
package comp_pkg;

  localparam logic [1:0] CMP_GT = 2'b00;
  localparam logic [1:0] CMP_GE = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_EQ = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Every mode is derived from the same two flags, so the per-digit datapath
  // never needs to know which relation the consumer asked for.
  function automatic logic modeResult(input logic [1:0] mode,
                                      input logic       gt,
                                      input logic       eq);
    logic res;
    case (mode)
      CMP_GT:  res = gt;
      CMP_GE:  res = gt | eq;
      CMP_LT:  res = ~gt & ~eq;
      default: res = eq;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/digit_serial_comparator_if.sv
// ---------------------------------------------------------------------------
// digit_serial_comparator_if
//   Operand and result handshakes of the digit-serial comparator.
//   Producer side : in_valid, x_a, x_b, mode, is_signed -> in_ready
//   Consumer side : out_valid, result, gt, eq          -> out_ready
//   master = the environment (producer + consumer), slave = the comparator.
// ---------------------------------------------------------------------------
interface digit_serial_comparator_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] x_b;
  logic [1:0]       mode;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             gt;
  logic             eq;

  modport master (
    output in_valid, x_a, x_b, mode, is_signed, out_ready,
    input  in_ready, out_valid, result, gt, eq
  );

  modport slave (
    input  in_valid, x_a, x_b, mode, is_signed, out_ready,
    output in_ready, out_valid, result, gt, eq
  );

endinterface

// File: rtl/comp_digit.sv
// ---------------------------------------------------------------------------
// comp_digit
//   Purely combinational unsigned compare of one DIGIT-bit slice.
//   a_i, b_i : slice operands
//   gt_o     : a_i >  b_i
//   eq_o     : a_i == b_i
//   Built as a log-depth tree of pairwise (gt, eq) merges so it can also be
//   reused as the core of wider tree comparators.
// ---------------------------------------------------------------------------
module comp_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             gt_o,
  output logic             eq_o
);

  // The tree wants a power-of-two leaf count; the extra leaves are zero in
  // both operands, which makes them neutral (gt=0, eq=1) in any merge.
  localparam int LEAVES = 1 << $clog2(DIGIT);

  // Each level merges neighbouring (hi, lo) pairs in place:
  //   gt = gt_hi | (eq_hi & gt_lo),  eq = eq_hi & eq_lo
  // Pair i reads leaves 2i (lo) and 2i+1 (hi) and writes slot i, which has
  // already been consumed, so one vector per flag is enough.
  function automatic logic [1:0] treeCompare(input logic [LEAVES-1:0] a,
                                             input logic [LEAVES-1:0] b);
    logic [LEAVES-1:0] g;
    logic [LEAVES-1:0] e;
    g = a & ~b;
    e = ~(a ^ b);
    for (int w = LEAVES / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        g[i] = g[2*i+1] | (e[2*i+1] & g[2*i]);
        e[i] = e[2*i+1] & e[2*i];
      end
    end
    return {g[0], e[0]};
  endfunction

  logic [1:0] merged;

  assign merged = treeCompare(LEAVES'(a_i), LEAVES'(b_i));
  assign gt_o   = merged[1];
  assign eq_o   = merged[0];

endmodule

// File: rtl/digit_serial_comparator.sv
// ---------------------------------------------------------------------------
// digit_serial_comparator
//   Magnitude comparator that walks two WIDTH-bit operands MSB digit first,
//   DIGIT bits per clock, and reports the selected relation.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of digit_serial_comparator_if
//              (in_valid/in_ready operand handshake, out_valid/out_ready
//               result handshake, result/gt/eq registered outputs)
//   Latency is always WIDTH/DIGIT cycles from accept to out_valid, whatever
//   the operand values, so the block is safe for constant-time use.
// ---------------------------------------------------------------------------
module digit_serial_comparator
  import comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic                       clk,
  input logic                       rst,
  digit_serial_comparator_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

  state_t           state_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [1:0]       mode_q;
  logic [IDXW-1:0]  idx_q;
  logic             accGt_q;
  logic             accEq_q;
  logic             inReady_q;
  logic             outValid_q;
  logic             result_q;
  logic             gt_q;
  logic             eq_q;

  logic [WIDTH-1:0] signMask;
  logic             digitGt;
  logic             digitEq;
  logic             accGt_d;
  logic             accEq_d;

  // Flipping the sign bit maps two's-complement onto offset binary, so one
  // unsigned datapath serves both signed and unsigned compares.
  assign signMask = WIDTH'(bus.is_signed) << (WIDTH - 1);

  // The operand registers shift left by one digit per RUN cycle, so the
  // digit selected by idx_q always sits in the top DIGIT bits.
  comp_digit #(
    .DIGIT (DIGIT)
  ) uDigit (
    .a_i  (opA_q[WIDTH-1 -: DIGIT]),
    .b_i  (opB_q[WIDTH-1 -: DIGIT]),
    .gt_o (digitGt),
    .eq_o (digitEq)
  );

  // A lower digit only decides the outcome while every higher digit tied.
  assign accGt_d = accGt_q | (accEq_q & digitGt);
  assign accEq_d = accEq_q & digitEq;

  // Sequencer: accept a pair in IDLE, grind through NDIG digits in RUN, then
  // hold the registered result in DONE until the consumer takes it. All
  // handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      result_q   <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      idx_q      <= '0;
      accGt_q    <= 1'b0;
      accEq_q    <= 1'b1;
      opA_q      <= '0;
      opB_q      <= '0;
      mode_q     <= CMP_GT;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone is the fire.
          if (bus.in_valid) begin
            opA_q     <= bus.x_a ^ signMask;
            opB_q     <= bus.x_b ^ signMask;
            mode_q    <= bus.mode;
            accGt_q   <= 1'b0;
            accEq_q   <= 1'b1;
            idx_q     <= LAST_IDX;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          accGt_q <= accGt_d;
          accEq_q <= accEq_d;
          opA_q   <= opA_q << DIGIT;
          opB_q   <= opB_q << DIGIT;
          idx_q   <= idx_q - 1'b1;
          if (idx_q == '0) begin
            gt_q       <= accGt_d;
            eq_q       <= accEq_d;
            result_q   <= modeResult(mode_q, accGt_d, accEq_d);
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.result    = result_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;

endmodule

// File: tb/tb_digit_serial_comparator.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_comparator
//   Self-checking bench for digit_serial_comparator. The main instance is
//   WIDTH=32/DIGIT=8 with directed vectors; two extra instances (8/1 and
//   16/16) get loops of boundary and random pairs. Expected values come from
//   an arithmetic model operating on sign- or zero-extended integers.
// ---------------------------------------------------------------------------
module tb_digit_serial_comparator;
  import comp_pkg::*;

  localparam int WIDTH = 32;
  localparam int DIGIT = 8;
  localparam int NDIG  = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  digit_serial_comparator_if #(.WIDTH(WIDTH)) bus ();

  digit_serial_comparator #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Every comparison goes through here so the counts stay in one place.
  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  // Interprets a w-bit pattern as an integer, two's-complement when s=1.
  function automatic longint extend(input logic [63:0] v, input int w,
                                    input logic s);
    longint r;
    r = longint'(v);
    if (s && v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  // Returns {result, gt, eq} for integer operands under the given mode.
  function automatic logic [2:0] cmpModel(input longint sa, input longint sb,
                                          input logic [1:0] m);
    logic res;
    case (m)
      CMP_GT:  res = (sa > sb);
      CMP_GE:  res = (sa >= sb);
      CMP_LT:  res = (sa < sb);
      default: res = (sa == sb);
    endcase
    return {res, (sa > sb), (sa == sb)};
  endfunction

  // Transaction-level model of the main instance: tracks whether a pair may
  // be accepted, how many cycles remain until its result is due, and the
  // result it must carry.
  logic       mReady;
  logic       mValid;
  int         mRemain;
  logic [2:0] mExp;
  bit         monOn = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mReady  <= 1'b1;
      mValid  <= 1'b0;
      mRemain <= 0;
    end else if (mReady) begin
      if (bus.in_valid) begin
        mExp    <= cmpModel(extend(64'(bus.x_a), WIDTH, bus.is_signed),
                            extend(64'(bus.x_b), WIDTH, bus.is_signed),
                            bus.mode);
        mReady  <= 1'b0;
        mRemain <= NDIG;
      end
    end else if (!mValid) begin
      mRemain <= mRemain - 1;
      if (mRemain == 1) mValid <= 1'b1;
    end else if (bus.out_ready) begin
      mValid <= 1'b0;
      mReady <= 1'b1;
    end
  end

  // Compare the main instance against the model on every falling edge.
  always @(negedge clk) begin
    if (monOn) begin
      check("mon_in_ready", bus.in_ready, mReady);
      check("mon_out_valid", bus.out_valid, mValid);
      if (mValid) begin
        check("mon_result", bus.result, mExp[2]);
        check("mon_gt", bus.gt, mExp[1]);
        check("mon_eq", bus.eq, mExp[0]);
      end
    end
  end

  // Presents one operand pair and returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] m, input logic s);
    int waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("accept_ready", bus.in_ready, 1'b1);
    bus.x_a       = a;
    bus.x_b       = b;
    bus.mode      = m;
    bus.is_signed = s;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid after an accept and checks the latency.
  task automatic waitResult(input string name);
    int lat = 0;
    @(negedge clk);
    while (!bus.out_valid && lat < NDIG + 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, NDIG);
  endtask

  task automatic releaseResult();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic expRes,
                             input logic expGt, input logic expEq);
    waitResult(name);
    check({name, "_result"}, bus.result, expRes);
    check({name, "_gt"}, bus.gt, expGt);
    check({name, "_eq"}, bus.eq, expEq);
    releaseResult();
  endtask

  // Parameter sweep instances: 8-bit bit-serial and 16-bit single-digit.
  for (genvar g = 0; g < 2; g++) begin : sweep
    localparam int SW     = (g == 0) ? 8 : 16;
    localparam int SD     = (g == 0) ? 1 : 16;
    localparam int SNDIG  = SW / SD;
    localparam int NPAIRS = (g == 0) ? 200 : 100;

    logic sRst;
    bit   sDone = 1'b0;

    digit_serial_comparator_if #(.WIDTH(SW)) sBus ();

    digit_serial_comparator #(
      .WIDTH (SW),
      .DIGIT (SD)
    ) sDut (
      .clk (clk),
      .rst (sRst),
      .bus (sBus)
    );

    initial begin
      logic [SW-1:0] a;
      logic [SW-1:0] b;
      logic [1:0]    m;
      logic          s;
      logic [2:0]    expV;
      int            lat;
      sRst           = 1'b1;
      sBus.in_valid  = 1'b0;
      sBus.out_ready = 1'b0;
      sBus.x_a       = '0;
      sBus.x_b       = '0;
      sBus.mode      = CMP_GT;
      sBus.is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1 sRst = 1'b0;
      for (int n = 0; n < NPAIRS; n++) begin
        a = SW'($urandom);
        b = SW'($urandom);
        case (n % 8)
          0: begin a = '0; b = '0; end
          1: begin a = SW'(1) << (SW - 1); b = a - 1'b1; end
          2: begin a = '1; b = '0; end
          3: begin b = SW'(1) << (SW - 1); a = b - 1'b1; end
          default: if (n % 5 == 0) b = a;
        endcase
        m = 2'($urandom_range(0, 3));
        s = (n < 8) ? logic'(n / 4) : logic'($urandom_range(0, 1));
        expV = cmpModel(extend(64'(a), SW, s), extend(64'(b), SW, s), m);
        sBus.x_a       = a;
        sBus.x_b       = b;
        sBus.mode      = m;
        sBus.is_signed = s;
        sBus.in_valid  = 1'b1;
        @(posedge clk);
        #1 sBus.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!sBus.out_valid && lat < SNDIG + 10) begin
          @(negedge clk);
          lat++;
        end
        check("sweep_latency", lat, SNDIG);
        check("sweep_result", sBus.result, expV[2]);
        check("sweep_gt", sBus.gt, expV[1]);
        check("sweep_eq", sBus.eq, expV[0]);
        sBus.out_ready = 1'b1;
        @(posedge clk);
        #1 sBus.out_ready = 1'b0;
      end
      sDone = 1'b1;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence on the main instance.
  initial begin
    logic sawValid;
    int   waited;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_a       = '0;
    bus.x_b       = '0;
    bus.mode      = CMP_GT;
    bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 1'b0);
    check("rst_gt", bus.gt, 1'b0);
    check("rst_eq", bus.eq, 1'b0);
    monOn = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(32'h0000_0100, 32'h0000_00FF, CMP_GT, 1'b0);
    checkOutput("gt_unsigned", 1'b1, 1'b1, 1'b0);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, CMP_LT, 1'b1);
    checkOutput("lt_signed", 1'b1, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, CMP_LT, 1'b0);
    checkOutput("lt_unsigned", 1'b0, 1'b1, 1'b0);

    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, CMP_EQ, 1'b0);
    checkOutput("same_eq", 1'b1, 1'b0, 1'b1);
    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, CMP_GE, 1'b0);
    checkOutput("same_ge", 1'b1, 1'b0, 1'b1);
    applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, CMP_GT, 1'b0);
    checkOutput("same_gt", 1'b0, 1'b0, 1'b1);

    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, CMP_GT, 1'b1);
    checkOutput("min_vs_max_signed", 1'b0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, CMP_GT, 1'b0);
    checkOutput("min_vs_max_unsigned", 1'b1, 1'b1, 1'b0);
    applyStimulus(32'h1234_5678, 32'h1234_5679, CMP_LT, 1'b0);
    checkOutput("lsb_digit_lt", 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h8000_0000, CMP_GE, 1'b1);
    checkOutput("min_ge_signed", 1'b1, 1'b0, 1'b1);

    // Backpressure: result held for 5 stalled cycles while new operands wait.
    applyStimulus(32'd5, 32'd7, CMP_GE, 1'b0);
    waitResult("bp_first");
    bus.x_a      = 32'd9;
    bus.x_b      = 32'd3;
    bus.mode     = CMP_GT;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_result", bus.result, 1'b0);
      check("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.x_a       = 32'd3;
    bus.x_b       = 32'd9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checkOutput("bp_next", 1'b0, 1'b0, 1'b0);

    // Reset together with in_valid while idle: nothing may be accepted.
    bus.x_a      = 32'd1;
    bus.x_b      = 32'd0;
    bus.mode     = CMP_GT;
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_wins_in_ready", bus.in_ready, 1'b1);
    check("rst_wins_out_valid", bus.out_valid, 1'b0);

    // Reset during the second RUN cycle aborts the pair silently.
    applyStimulus(32'h0000_0010, 32'h0000_0020, CMP_LT, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_out_valid", bus.out_valid, 1'b0);
    sawValid = 1'b0;
    for (int k = 0; k < NDIG + 4; k++) begin
      @(negedge clk);
      sawValid = sawValid | bus.out_valid;
    end
    check("abort_no_result", sawValid, 1'b0);
    applyStimulus(32'hCAFE_0000, 32'hCAFE_0001, CMP_LT, 1'b1);
    checkOutput("after_abort", 1'b1, 1'b0, 1'b0);

    // Random pairs checked by the model; odd iterations raise out_ready early.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = (n % 6 == 0) ? a : $urandom;
      if (n % 4 == 1) b = {a[31:8], b[7:0]};
      applyStimulus(a, b, 2'($urandom_range(0, 3)), logic'($urandom_range(0, 1)));
      if (n % 2 == 1) bus.out_ready = 1'b1;
      waitResult("random");
      releaseResult();
    end

    waited = 0;
    while (!(sweep[0].sDone && sweep[1].sDone) && waited < 40000) begin
      @(posedge clk);
      waited++;
    end
    check("sweep_complete", {sweep[0].sDone, sweep[1].sDone}, 2'b11);

    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_comparator.md
Name: digit_serial_comparator

Overview:
- Parametrised, digit-serial magnitude comparator. Successor to the fixed 8-bit combinational greater-than block.
- Compares two WIDTH-bit operands, MSB digit first, one DIGIT-bit slice per clock.
- Supports unsigned or signed operands and four compare modes (GT, GE, LT, EQ).
- Sits between operand producers and downstream selection/sorting logic behind valid/ready handshakes. Trades latency for a small, low-depth per-cycle cell.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits compared per cycle; 1 <= DIGIT <= WIDTH.
- NDIG (derived, localparam), WIDTH/DIGIT, number of compare cycles.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- x_a  in  WIDTH  operand A
- x_b  in  WIDTH  operand B
- mode  in  2  00=GT (A>B), 01=GE, 10=LT, 11=EQ
- is_signed  in  1  1 = two's-complement compare
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  1  selected-mode compare result
- gt  out  1  raw A>B flag
- eq  out  1  raw A==B flag

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, gt=0, eq=0, digit index=0.
- States and transitions:
  - IDLE: in_ready=1. When in_valid&in_ready at an edge:
    - latch x_a, x_b, mode, is_signed;
    - when is_signed=1, invert bit WIDTH-1 of both latched operands (signed-to-offset mapping);
    - set acc_gt=0, acc_eq=1, idx=NDIG-1;
    - go to RUN.
  - RUN: in_ready=0. Each edge, the digit cell compares slice idx of A and B, giving dgt and deq:
    - acc_gt <= acc_gt | (acc_eq & dgt);
    - acc_eq <= acc_eq & deq;
    - idx decrements.
    - The edge that processes idx=0 moves to DONE.
  - DONE: out_valid=1, with result, gt and eq registered and stable.
    - gt=acc_gt, eq=acc_eq.
    - result: GT→gt; GE→gt|eq; LT→~gt&~eq; EQ→eq.
    - Holds until out_valid&out_ready at an edge, then goes to IDLE and out_valid drops.
- Latency: accept at edge t → out_valid high in the cycle after edge t+NDIG (NDIG cycles in RUN). With DIGIT=WIDTH, the result is valid one cycle after accept.
- Throughput: one comparison per NDIG+2 cycles minimum. No overlap. in_ready is low in RUN and DONE.
- Timing of the handshake signals:
  - in_valid while in_ready=0 is ignored; no queuing.
  - x_a/x_b changing after acceptance has no effect.
  - out_ready while out_valid=0 is ignored.
- No early termination: latency is fixed and data-independent (required for constant-time use).
- rst mid-RUN or mid-DONE: next cycle is the reset state. The pending result is discarded; out_valid never pulses.
- rst and in_valid in the same cycle: reset wins; no operand is accepted.

Decomposition:
- Shared package comp_pkg holds:
  - mode encodings CMP_GT=2'b00, CMP_GE=2'b01, CMP_LT=2'b10, CMP_EQ=2'b11;
  - state enum IDLE/RUN/DONE;
  - a function mapping (mode, gt, eq) → result.
- Sub-module comp_digit (parameter DIGIT), purely combinational:
  - outputs DIGIT-bit dgt/deq from a log-depth tree of pairwise GT/XNOR-equal merges;
  - merge rule: gt_hi | (eq_hi & gt_lo); eq = eq_hi & eq_lo.
  - comp_digit is reused by future tree comparators.
- Top level holds the FSM, operand registers, index counter and accumulators.

Test Plan (defaults WIDTH=32, DIGIT=8 unless stated):
- x_a=0x00000100, x_b=0x000000FF, mode=GT, unsigned → out_valid exactly 4 cycles after accept; result=1, gt=1, eq=0.
- x_a=0xFFFFFFFF, x_b=0x00000001, mode=LT, is_signed=1 → result=1. Same operands with is_signed=0 → result=0, gt=1.
- x_a=x_b=0xDEADBEEF in modes EQ, GE, GT → result 1, 1, 0 respectively; eq=1 in all three.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, and drive in_valid=1 with new operands throughout:
  - out_valid and result stay stable; in_ready=0;
  - after out_ready=1, the next comparison uses only operands presented once in_ready=1.
- Assert rst for 1 cycle in the 2nd RUN cycle:
  - next cycle in_ready=1, out_valid=0;
  - no result is emitted for the aborted pair;
  - a subsequent pair completes normally.
- Parameter sweep:
  - WIDTH=8, DIGIT=1: exhaustive 65536 pairs × 4 modes × signed/unsigned against a behavioural model; latency 8.
  - WIDTH=16, DIGIT=16: random pairs, latency 1.
